// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster generator with windowed pixel fetch.
// Ports: VGA_CLK_IN/rst, mode, memPx in; px_addr, syncs, blank, frame_start, RGB, VGA_CLK_OUT out.
// Optional macro VGA_TESTPAT_EN: mode 3 draws 8 vertical colour bars.
module vga_timing_gen #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int          WIN_X0   = 100,
  parameter int          WIN_Y0   = 100,
  parameter int          WIN_W    = 300,
  parameter int          WIN_H    = 300,
  parameter logic [31:0] PX_BASE  = 32'd24,
  parameter logic [23:0] BG_COLOR = 24'h10A6ED
) (
  input  logic        VGA_CLK_IN,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [7:0]  memPx,
  output logic [31:0] px_addr,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_blank,
  output logic        o_frame_start,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic        VGA_CLK_OUT
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] WX0    = HW'(WIN_X0);
  localparam logic [HW-1:0] WX1    = HW'(WIN_X0 + WIN_W);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] WY0    = VW'(WIN_Y0);
  localparam logic [VW-1:0] WY1    = VW'(WIN_Y0 + WIN_H);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          act0, win0, hs0, vs0, fs0, frame_end;
  logic          act1, win1, hs1, vs1, fs1;
  logic [1:0]    mode_q;
  logic [23:0]   rgb;

  assign VGA_CLK_OUT = VGA_CLK_IN;

  // Stage 0 decode
  assign act0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign win0 = act0 &&
                (h_cnt >= WX0) && (h_cnt < WX1) &&
                (v_cnt >= WY0) && (v_cnt < WY1);
  assign hs0 = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs0 = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign fs0 = (h_cnt == '0) && (v_cnt == '0);
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  always_ff @(posedge VGA_CLK_IN) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Address for the pixel at the current counter position; the
  // frame-end reload keeps the fetch locked to the raster.
  always_ff @(posedge VGA_CLK_IN) begin
    if (rst || frame_end) px_addr <= PX_BASE;
    else if (win0)        px_addr <= px_addr + 32'd1;
  end

  // Mode only changes across a frame boundary.
  always_ff @(posedge VGA_CLK_IN) begin
    if (rst)            mode_q <= 2'd0;
    else if (frame_end) mode_q <= mode;
  end

  // Stage 1: flags aligned with memPx
  always_ff @(posedge VGA_CLK_IN) begin
    if (rst) begin
      act1 <= 1'b0;
      win1 <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      fs1  <= 1'b0;
    end else begin
      act1 <= act0;
      win1 <= win0;
      hs1  <= hs0;
      vs1  <= vs0;
      fs1  <= fs0;
    end
  end

`ifdef VGA_TESTPAT_EN
  localparam int HB = HW + 3;
  logic [HB-1:0] h8;
  logic [2:0]    bar0, bar1;
  logic [23:0]   bar_rgb;

  assign h8   = {h_cnt, 3'b000};
  assign bar0 = 3'(h8 / HB'(H_ACTIVE));
  // Bar order white..black maps each channel to an inverted index bit.
  assign bar_rgb = {{8{~bar1[1]}}, {8{~bar1[2]}}, {8{~bar1[0]}}};

  always_ff @(posedge VGA_CLK_IN) begin
    if (rst) bar1 <= 3'd0;
    else     bar1 <= bar0;
  end
`endif

  // Stage 2 colour select
  always_comb begin
    rgb = 24'h000000;
    if (act1) begin
      rgb = BG_COLOR;
      if (win1 && mode_q == 2'd0)
        rgb = {memPx, memPx, memPx};
      if (win1 && mode_q == 2'd1)
        rgb = {memPx[7:5], memPx[7:5], memPx[7:6],
               memPx[4:2], memPx[4:2], memPx[4:3],
               {4{memPx[1:0]}}};
`ifdef VGA_TESTPAT_EN
      if (mode_q == 2'd3)
        rgb = bar_rgb;
`endif
    end
  end

  always_ff @(posedge VGA_CLK_IN) begin
    if (rst) begin
      o_hsync       <= ~HS_POL;
      o_vsync       <= ~VS_POL;
      o_blank       <= 1'b1;
      o_frame_start <= 1'b0;
      o_red         <= 8'h00;
      o_green       <= 8'h00;
      o_blue        <= 8'h00;
    end else begin
      o_hsync       <= hs1 ? HS_POL : ~HS_POL;
      o_vsync       <= vs1 ? VS_POL : ~VS_POL;
      o_blank       <= ~act1;
      o_frame_start <= fs1 & act1;
      o_red         <= rgb[23:16];
      o_green       <= rgb[15:8];
      o_blue        <= rgb[7:0];
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen on a reduced raster
// (24x17 total, 16x12 active, 6x5 window at (4,3), base 24).
module tb_vga_timing_gen;

  localparam int HT = 24;
  localparam int VT = 17;
  localparam int FR = HT * VT;
  localparam logic [23:0] BG = 24'h10A6ED;
`ifdef VGA_TESTPAT_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  memPx;
  logic        mem_fixed = 1'b0;
  logic [7:0]  mem_val = 8'h00;
  logic [31:0] px_addr;
  logic        o_hsync, o_vsync, o_blank, o_frame_start;
  logic [7:0]  o_red, o_green, o_blue;
  logic        clk_out;
  logic [23:0] rgb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit agg_on = 1'b0;
  int hs_low = 0, vs_low = 0, blanks = 0;
  int fs_n = 0, fs_last = -1, hs_first = -1;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .WIN_X0(4), .WIN_Y0(3), .WIN_W(6), .WIN_H(5),
    .PX_BASE(32'd24), .BG_COLOR(BG)
  ) dut (
    .VGA_CLK_IN(clk),
    .rst(rst),
    .mode(mode),
    .memPx(memPx),
    .px_addr(px_addr),
    .o_hsync(o_hsync),
    .o_vsync(o_vsync),
    .o_blank(o_blank),
    .o_frame_start(o_frame_start),
    .o_red(o_red),
    .o_green(o_green),
    .o_blue(o_blue),
    .VGA_CLK_OUT(clk_out)
  );

  assign rgb = {o_red, o_green, o_blue};

  always #5 clk = ~clk;

  // One-clock-latency memory returning the low address byte
  always @(posedge clk)
    memPx <= mem_fixed ? mem_val : px_addr[7:0];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (agg_on && cyc >= 2 && cyc < 2 + 2 * FR) begin
      if (!o_hsync) hs_low++;
      if (!o_vsync) vs_low++;
      if (o_blank) blanks++;
      if (o_frame_start) begin
        fs_n++;
        fs_last = cyc;
      end
      if (!o_hsync && hs_first < 0) hs_first = cyc;
    end
  endtask

  // Advance until the outputs show raster position (x,y) of frame f
  task automatic at_out(input int f, input int x, input int y);
    int idx;
    idx = f * FR + y * HT + x + 2;
    while (cyc < idx) step();
  endtask

  // Advance until the counters sit at (x,y) of frame f
  task automatic at_cnt(input int f, input int x, input int y);
    int idx;
    idx = f * FR + y * HT + x;
    while (cyc < idx) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    chk("rst_hsync", 32'(o_hsync), 32'd1);
    chk("rst_vsync", 32'(o_vsync), 32'd1);
    chk("rst_blank", 32'(o_blank), 32'd1);
    chk("rst_fs", 32'(o_frame_start), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_addr", px_addr, 32'd24);
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    do_reset();
    agg_on = 1'b1;
    chk("px_first", px_addr, 32'd24);

    at_out(0, 0, 0);
    chk("fs0", 32'(o_frame_start), 32'd1);
    chk("blank0", 32'(o_blank), 32'd0);
    chk("bg00", 32'(rgb), 32'(BG));
    at_out(0, 1, 0);
    chk("fs1", 32'(o_frame_start), 32'd0);
    at_out(0, 3, 3);
    chk("bg_left", 32'(rgb), 32'(BG));
    at_out(0, 4, 3);
    chk("win_first", 32'(rgb), 32'h181818);
    at_cnt(0, 10, 7);
    chk("px_after", px_addr, 32'd54);
    at_out(0, 9, 7);
    chk("win_last", 32'(rgb), 32'h353535);
    at_out(0, 10, 7);
    chk("bg_right", 32'(rgb), 32'(BG));
    at_cnt(0, 23, 16);
    chk("px_hold", px_addr, 32'd54);
    at_cnt(1, 0, 0);
    chk("px_reload", px_addr, 32'd24);

    at_out(1, 0, 5);
    mode = 2'd1;
    at_out(1, 4, 6);
    chk("gray_keep", 32'(rgb), 32'h2A2A2A);

    at_out(2, 0, 0);
    agg_on = 1'b0;
    chk("hs_low", 32'(hs_low), 32'd102);
    chk("vs_low", 32'(vs_low), 32'd96);
    chk("blanks", 32'(blanks), 32'd432);
    chk("fs_n", 32'(fs_n), 32'd2);
    chk("fs_last", 32'(fs_last), 32'd410);
    chk("hs_first", 32'(hs_first), 32'd20);
    chk("fs2", 32'(o_frame_start), 32'd1);

    at_out(2, 4, 3);
    chk("rgb332", 32'(rgb), 32'h00DB00);
    mem_fixed = 1'b1;
    mem_val = 8'hE0;

    at_out(3, 0, 0);
    chk("m1_out", 32'(rgb), 32'(BG));
    at_out(3, 4, 3);
    chk("m1_red", 32'(rgb), 32'hFF0000);
    at_out(3, 20, 3);
    chk("m1_blank", 32'(o_blank), 32'd1);
    chk("m1_blk_rgb", 32'(rgb), 32'h0);
    mode = 2'd2;

    at_out(4, 4, 3);
    chk("m2_win", 32'(rgb), 32'(BG));
    mode = 2'd3;

    at_out(5, 0, 0);
    chk("bar0", 32'(rgb), TP ? 32'hFFFFFF : 32'(BG));
    at_out(5, 2, 0);
    chk("bar1", 32'(rgb), TP ? 32'hFFFF00 : 32'(BG));
    at_out(5, 4, 3);
    chk("bar_win", 32'(rgb), TP ? 32'h00FFFF : 32'(BG));
    at_out(5, 15, 0);
    chk("bar7", 32'(rgb), TP ? 32'h000000 : 32'(BG));

    at_out(5, 0, 9);
    mem_fixed = 1'b0;
    do_reset();
    chk("px_rst", px_addr, 32'd24);
    at_out(0, 0, 0);
    chk("fs_rst", 32'(o_frame_start), 32'd1);
    at_out(0, 4, 3);
    chk("gray_rst", 32'(rgb), 32'h181818);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster generator that replaces the fixed 640x480 sync block in the display path. It produces hsync/vsync/blank, fetches a rectangular image window from synchronous pixel memory with a frame-locked address counter, and outputs registered 24-bit RGB. It sits between the pixel memory read port and the VGA DAC, and keeps all outputs pipeline-aligned to the memory read latency.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync lengths in clocks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync lengths in lines
- HS_POL / VS_POL, 0 / 0, sync active level (0 = active-low)
- WIN_X0 / WIN_Y0, 100 / 100, window origin in active coordinates
- WIN_W / WIN_H, 300 / 300, window size in pixels
- PX_BASE, 24, memory address of window pixel (0,0)
- BG_COLOR, 24'h10A6ED, colour of active area outside the window
- VGA_CLK_IN  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  2  0 gray8, 1 RGB332, 2 solid BG_COLOR, 3 colour bars (see Configuration)
- memPx  in  8  pixel data, valid one clock after px_addr
- px_addr  out  32  pixel memory read address
- o_hsync / o_vsync  out  1  sync pulses at HS_POL/VS_POL
- o_blank  out  1  high outside the active area
- o_frame_start  out  1  one-clock pulse with first active pixel of a frame
- o_red / o_green / o_blue  out  8  colour, forced 0 when o_blank
- VGA_CLK_OUT  out  1  equals VGA_CLK_IN

## Operation
- Stage 0: h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params); v_cnt 0..V_TOTAL-1, increments when h_cnt wraps. Line order: active, FP, sync, BP.
- Active = h_cnt < H_ACTIVE and v_cnt < V_ACTIVE. In-window = active and WIN_X0 <= h_cnt < WIN_X0+WIN_W and WIN_Y0 <= v_cnt < WIN_Y0+WIN_H.
- px_addr: register; loads PX_BASE when h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1 (frame start); increments by 1 on each in-window clock; holds otherwise. Never free-runs across frames.
- Stage 1: memPx arrives; in-window/active/sync flags delayed one clock.
- Stage 2 (output registers): colour select
  - not active: 0
  - active, not in-window, or mode 2: BG_COLOR
  - mode 0: {memPx, memPx, memPx}
  - mode 1: R = {p[7:5],p[7:5],p[7:6]}, G = {p[4:2],p[4:2],p[4:3]}, B = {p[1:0] x4}
- mode sampled at frame start only; changes mid-frame take effect next frame.
- Reset: h_cnt=v_cnt=0, px_addr=PX_BASE, o_hsync=!HS_POL, o_vsync=!VS_POL, o_blank=1, RGB=0, o_frame_start=0, pipeline flags cleared, latched mode=0. Reset mid-frame restarts at pixel (0,0) of a new frame on the clock after rst falls.

## Timing
- Counter state at clock t appears on all outputs at t+2; syncs, blank, frame_start and RGB mutually aligned.
- px_addr for counter position t is valid at t (registered one clock earlier); memory must return data at t+1.
- Window parameters must satisfy WIN_X0+WIN_W <= H_ACTIVE, WIN_Y0+WIN_H <= V_ACTIVE; px_addr after last window pixel = PX_BASE + WIN_W*WIN_H and holds until frame start.
- Counter widths: $clog2(H_TOTAL), $clog2(V_TOTAL).

## Configuration
- VGA_TESTPAT_EN defined: mode 3 draws 8 vertical colour bars over the full active area (bar = h_cnt*8/H_ACTIVE; white, yellow, cyan, green, magenta, red, blue, black, components 8'hFF/0), ignoring window and memPx; px_addr behaviour unchanged.
- Not defined: mode 3 behaves exactly as mode 2.

## Test plan
- Reset, default params, 2 frames -> hsync low 96 clocks per 800-clock line, vsync low 2 lines per 525-line frame, frame_start every 420000 clocks.
- Window (100,100) 300x300, memory returns addr[7:0] -> first window pixel RGB = 8'h18 each channel at output position (100,100); px_addr = 90024 after window, reloads 24 at frame start.
- mode 1, memPx=8'hE0 in window -> RGB = FF/00/00; outside window = 10A6ED; blanking = 000000.
- mode changed 0->1 at line 200 -> gray persists until next frame_start, then RGB332.
- rst pulsed at line 300 -> outputs at reset values next clock; after release, frame_start 2 clocks later... at first active pixel, px_addr = 24.
- VGA_TESTPAT_EN, mode 3 -> pixel 0 = FFFFFF, pixel 80 = FFFF00, pixel 639 = 000000; undefined build -> 10A6ED.
